// File: rtl/rams_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NREQ_ valid/ready requesters,
// with a per-beat lock for atomic read-modify-write and a registered read response.
module rams_arbiter #(
  parameter int NREQ_ = 2,
  parameter int DATA_ = 8,
  parameter int ADDR_ = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ_-1:0]       req_valid,
  output logic [NREQ_-1:0]       req_ready,
  input  logic [NREQ_-1:0]       req_we,
  input  logic [NREQ_-1:0]       req_lock,
  input  logic [NREQ_*ADDR_-1:0] req_addr,
  input  logic [NREQ_*DATA_-1:0] req_din,
  output logic [NREQ_-1:0]       rsp_valid,
  output logic [DATA_-1:0]       rsp_data,
  output logic                   ram_ena,
  output logic                   ram_we,
  output logic [ADDR_-1:0]       ram_addr,
  output logic [DATA_-1:0]       ram_din,
  input  logic [DATA_-1:0]       ram_dout
);

  localparam int PW = (NREQ_ > 1) ? $clog2(NREQ_) : 1;

  typedef enum logic {ARB, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [NREQ_-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_-1:0]  rsp_data_q, rsp_data_d;

  logic              found;
  logic [PW-1:0]     g;
  int                idx;

  // While locked only the owner is eligible; otherwise scan from ptr with wrap.
  always_comb begin
    found = 1'b0;
    g     = '0;
    idx   = 0;
    if (state_q == LOCKED) begin
      found = req_valid[owner_q];
      g     = owner_q;
    end else begin
      for (int k = 0; k < NREQ_; k++) begin
        idx = (int'(ptr_q) + k) % NREQ_;
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          g     = PW'(idx);
        end
      end
    end
  end

  always_comb begin
    req_ready   = '0;
    ram_ena     = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_din     = '0;
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (found) begin
      req_ready[g] = 1'b1;
      ram_ena      = 1'b1;
      ram_we       = req_we[g];
      ram_addr     = req_addr[g*ADDR_ +: ADDR_];
      ram_din      = req_din[g*DATA_ +: DATA_];
      if (req_lock[g]) begin
        state_d = LOCKED;
        owner_d = g;
      end else begin
        state_d = ARB;
        ptr_d   = PW'((int'(g) + 1) % NREQ_);
      end
      if (!req_we[g]) begin
        rsp_valid_d[g] = 1'b1;
        rsp_data_d     = ram_dout;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      ptr_q       <= '0;
      owner_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_rams_arbiter.sv
// Bench for rams_arbiter with four requesters and a behavioural RAM; read responses
// are predicted from a shadow memory and checked through a scoreboard queue.
module tb_rams_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [N*8-1:0] req_addr, req_din;
  logic [7:0]    rsp_data, ram_addr, ram_din, ram_dout;
  logic          ram_ena, ram_we;

  typedef struct packed { logic [N-1:0] oh; logic [7:0] data; } exp_t;
  exp_t sb[$];

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] mem [256];
  logic [7:0] shadow [256];
  bit         init_done = 1'b0;

  rams_arbiter #(.NREQ_(N), .DATA_(8), .ADDR_(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_din(req_din),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_ena(ram_ena), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port RAM with combinational read, write at the edge, no reset.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int a = 0; a < 256; a++) mem[a] <= 8'(a) ^ 8'h5A;
      init_done <= 1'b1;
    end else if (ram_ena && ram_we) begin
      mem[ram_addr] <= ram_din;
    end
  end
  assign ram_dout = mem[ram_addr];

  // Response checker: entries pushed in a grant cycle are due the following cycle.
  always begin
    @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total_cnt++;
      if (rsp_valid !== e.oh || rsp_data !== e.data)
        $display("FAIL rsp: got valid=%b data=%h want valid=%b data=%h", rsp_valid, rsp_data, e.oh, e.data);
      else pass_cnt++;
    end else begin
      total_cnt++;
      if (rsp_valid !== '0) $display("FAIL rsp_idle: got valid=%b want 0", rsp_valid);
      else pass_cnt++;
    end
  end

  task automatic clr_all();
    req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_din = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic lock,
                         input logic [7:0] addr, input logic [7:0] din);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_lock[i]  = lock;
    req_addr[i*8 +: 8] = addr;
    req_din[i*8 +: 8]  = din;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clr_all();
    sb.delete();
    #7;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clr_all();
    repeat (3) next_cyc();
    total_cnt++;
    if (rsp_valid !== '0 || rsp_data !== 8'h00) $display("FAIL reset_rsp: got %b/%h want 0/00", rsp_valid, rsp_data);
    else pass_cnt++;
    total_cnt++;
    if (req_ready !== '0 || ram_ena !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 8'h00 || ram_din !== 8'h00)
      $display("FAIL reset_comb: got rdy=%b ena=%b we=%b addr=%h din=%h want all 0", req_ready, ram_ena, ram_we, ram_addr, ram_din);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    next_cyc();
    clr_all(); set_req(0, 1'b1, 1'b0, 8'h10, 8'hA5);
    #3;
    total_cnt++;
    if (req_ready !== 4'b0001 || ram_ena !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h10 || ram_din !== 8'hA5)
      $display("FAIL wr_beat: got rdy=%b ena=%b we=%b addr=%h din=%h want 0001 1 1 10 a5", req_ready, ram_ena, ram_we, ram_addr, ram_din);
    else pass_cnt++;
    shadow[8'h10] = 8'hA5;
    next_cyc();
    clr_all(); set_req(0, 1'b0, 1'b0, 8'h10, 8'h00);
    #3;
    total_cnt++;
    if (req_ready !== 4'b0001 || ram_we !== 1'b0) $display("FAIL rd_beat: got rdy=%b we=%b want 0001 0", req_ready, ram_we);
    else pass_cnt++;
    sb.push_back('{oh: 4'b0001, data: shadow[8'h10]});
    next_cyc();
    clr_all();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] want;
    next_cyc();
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      next_cyc();
      clr_all();
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 8'h40 + 8'(i), 8'h00);
      #3;
      want = 4'b0001 << (c % N);
      total_cnt++;
      if (req_ready !== want) $display("FAIL rr_grant%0d: got %b want %b", c, req_ready, want);
      else pass_cnt++;
      sb.push_back('{oh: want, data: shadow[8'h40 + 8'(c % N)]});
    end
  endtask

  task automatic test_skip();
    next_cyc();
    clr_all(); set_req(1, 1'b0, 1'b0, 8'h41, 8'h00);
    #3;
    total_cnt++;
    if (req_ready !== 4'b0010) $display("FAIL skip_setup: got %b want 0010", req_ready);
    else pass_cnt++;
    sb.push_back('{oh: 4'b0010, data: shadow[8'h41]});
    next_cyc();
    clr_all(); set_req(0, 1'b0, 1'b0, 8'h50, 8'h00); set_req(3, 1'b0, 1'b0, 8'h53, 8'h00);
    #3;
    total_cnt++;
    if (req_ready !== 4'b1000) $display("FAIL skip_first: got %b want 1000", req_ready);
    else pass_cnt++;
    sb.push_back('{oh: 4'b1000, data: shadow[8'h53]});
    next_cyc();
    clr_all(); set_req(0, 1'b0, 1'b0, 8'h50, 8'h00);
    #3;
    total_cnt++;
    if (req_ready !== 4'b0001) $display("FAIL skip_wrap: got %b want 0001", req_ready);
    else pass_cnt++;
    sb.push_back('{oh: 4'b0001, data: shadow[8'h50]});
    next_cyc();
    clr_all();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 8'h60 + 8'(i), 8'h00);
    #3;
    total_cnt++;
    if (req_ready !== 4'b0010) $display("FAIL skip_ptr: got %b want 0010", req_ready);
    else pass_cnt++;
    sb.push_back('{oh: 4'b0010, data: shadow[8'h61]});
  endtask

  task automatic test_lock();
    next_cyc();
    clr_all(); set_req(0, 1'b0, 1'b0, 8'h30, 8'h00);
    #3;
    total_cnt++;
    if (req_ready !== 4'b0001) $display("FAIL lock_setup: got %b want 0001", req_ready);
    else pass_cnt++;
    sb.push_back('{oh: 4'b0001, data: shadow[8'h30]});
    next_cyc();
    set_req(1, 1'b0, 1'b1, 8'h20, 8'h00);
    #3;
    total_cnt++;
    if (req_ready !== 4'b0010) $display("FAIL lock_rd: got %b want 0010", req_ready);
    else pass_cnt++;
    sb.push_back('{oh: 4'b0010, data: shadow[8'h20]});
    next_cyc();
    req_valid[1] = 1'b0;
    #3;
    total_cnt++;
    if (req_ready !== 4'b0000 || ram_ena !== 1'b0) $display("FAIL lock_idle: got rdy=%b ena=%b want 0000 0", req_ready, ram_ena);
    else pass_cnt++;
    next_cyc();
    set_req(1, 1'b1, 1'b0, 8'h20, 8'h21);
    #3;
    total_cnt++;
    if (req_ready !== 4'b0010 || ram_we !== 1'b1 || ram_din !== 8'h21) $display("FAIL lock_wr: got rdy=%b we=%b din=%h want 0010 1 21", req_ready, ram_we, ram_din);
    else pass_cnt++;
    shadow[8'h20] = 8'h21;
    next_cyc();
    req_valid[1] = 1'b0;
    #3;
    total_cnt++;
    if (req_ready !== 4'b0001) $display("FAIL lock_release: got %b want 0001", req_ready);
    else pass_cnt++;
    sb.push_back('{oh: 4'b0001, data: shadow[8'h30]});
    next_cyc();
    clr_all(); set_req(1, 1'b0, 1'b0, 8'h20, 8'h00);
    #3;
    total_cnt++;
    if (req_ready !== 4'b0010) $display("FAIL lock_reread: got %b want 0010", req_ready);
    else pass_cnt++;
    sb.push_back('{oh: 4'b0010, data: shadow[8'h20]});
  endtask

  task automatic test_reset_locked();
    next_cyc();
    clr_all(); set_req(2, 1'b0, 1'b1, 8'h10, 8'h00);
    #3;
    total_cnt++;
    if (req_ready !== 4'b0100) $display("FAIL rl_grant: got %b want 0100", req_ready);
    else pass_cnt++;
    sb.push_back('{oh: 4'b0100, data: shadow[8'h10]});
    @(posedge clk);
    #1;
    total_cnt++;
    if (rsp_valid !== 4'b0100 || rsp_data !== shadow[8'h10]) $display("FAIL rl_pending: got %b/%h want 0100/%h", rsp_valid, rsp_data, shadow[8'h10]);
    else pass_cnt++;
    sb.delete();
    clr_all();
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (rsp_valid !== '0) $display("FAIL rl_async: got %b want 0000", rsp_valid);
    else pass_cnt++;
    #1;
    rst_n = 1'b1;
    next_cyc();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 8'h70 + 8'(i), 8'h00);
    #3;
    total_cnt++;
    if (req_ready !== 4'b0001) $display("FAIL rl_after: got %b want 0001", req_ready);
    else pass_cnt++;
    sb.push_back('{oh: 4'b0001, data: shadow[8'h70]});
  endtask

  task automatic test_idle();
    for (int c = 0; c < 3; c++) begin
      next_cyc();
      clr_all();
      #3;
      total_cnt++;
      if (req_ready !== '0 || ram_ena !== 1'b0 || ram_we !== 1'b0) $display("FAIL idle%0d: got rdy=%b ena=%b we=%b want 0", c, req_ready, ram_ena, ram_we);
      else pass_cnt++;
    end
    next_cyc();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 8'h80 + 8'(i), 8'h00);
    #3;
    total_cnt++;
    if (req_ready !== 4'b0010) $display("FAIL idle_ptr: got %b want 0010", req_ready);
    else pass_cnt++;
    sb.push_back('{oh: 4'b0010, data: shadow[8'h81]});
  endtask

  initial begin
    for (int a = 0; a < 256; a++) shadow[a] = 8'(a) ^ 8'h5A;
    clr_all();
    test_reset();
    test_write_read();
    test_round_robin();
    test_skip();
    test_lock();
    test_reset_locked();
    test_idle();
    next_cyc();
    clr_all();
    repeat (3) next_cyc();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
